// File: rtl/add_n_pipe_pkg.sv
// Shared averager definitions: rounding-mode codes, legal size range, log2 helper.
// Latency: n/a (constants and elaboration-time functions only).
// Backpressure: n/a.
package add_n_pipe_pkg;

  localparam int RND_TRUNC  = 0;
  localparam int RND_HALFUP = 1;
  localparam int RND_CONV   = 2;

  localparam int LOG_N_MIN = 1;
  localparam int LOG_N_MAX = 4;

  // Smallest r with 2**r >= val; used at elaboration time to size/check trees.
  function automatic int log2_ceil(input int val);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < val) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/add_n_round.sv
// Registered scale-by-2**-LOG_N stage with truncate / half-up / half-even rounding.
// Latency: 1 cycle from sum_vld to res_vld.
// Backpressure: none; a result is produced for every valid sum, output holds otherwise.
module add_n_round
  import add_n_pipe_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int LOG_N      = 2,
  parameter int ROUND_MODE = RND_TRUNC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sum_vld,
  input  logic [WIDTH+LOG_N-1:0] sum_dat,
  output logic                   res_vld,
  output logic [WIDTH-1:0]       res_dat
);

  localparam int SW = WIDTH + LOG_N;
  localparam logic [SW-1:0] HALF = SW'(1) << (LOG_N - 1);

  if (ROUND_MODE != RND_TRUNC && ROUND_MODE != RND_HALFUP && ROUND_MODE != RND_CONV) begin : g_bad_mode
    $error("add_n_round: ROUND_MODE must be 0, 1 or 2");
  end

  logic [SW-1:0]    addend_c;
  logic [SW-1:0]    rnd_sum_c;
  logic [WIDTH-1:0] res_dat_d, res_dat_q;
  logic             res_vld_d, res_vld_q;
  logic             rnd_unused;

  // Rounding addend, then keep the top WIDTH bits (arithmetic shift by LOG_N).
  // The sum fits the result range by construction, so no saturation is needed.
  always_comb begin
    addend_c = '0;
    case (ROUND_MODE)
      RND_HALFUP: addend_c = HALF;
      RND_CONV:   addend_c = HALF - SW'(1) + SW'(sum_dat[LOG_N]);
      default:    addend_c = '0;
    endcase
    rnd_sum_c = sum_dat + addend_c;
    res_vld_d = sum_vld;
    res_dat_d = res_dat_q;
    if (sum_vld) res_dat_d = rnd_sum_c[SW-1:LOG_N];
  end

  // The fractional bits are discarded by design.
  assign rnd_unused = &{1'b0, rnd_sum_c[LOG_N-1:0]};

  // Result and strobe registers; reset clears both.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_vld_q <= 1'b0;
      res_dat_q <= '0;
    end else begin
      res_vld_q <= res_vld_d;
      res_dat_q <= res_dat_d;
    end
  end

  assign res_vld = res_vld_q;
  assign res_dat = res_dat_q;

endmodule

// File: rtl/add_n_pipe.sv
// Signed averager of 2**LOG_N samples: registered adder tree then rounding stage.
// Latency: LOG_N+1 cycles stb_in -> stb_out, one result per cycle.
// Backpressure: none; stb_in gaps propagate unchanged, out holds between strobes.
module add_n_pipe
  import add_n_pipe_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int LOG_N      = 2,
  parameter int ROUND_MODE = RND_TRUNC
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [(1<<LOG_N)*WIDTH-1:0]   in,
  input  logic                          stb_in,
  output logic [WIDTH-1:0]              out,
  output logic                          stb_out
);

  localparam int NUM_IN = 1 << LOG_N;
  localparam int SW     = WIDTH + LOG_N;

  if (LOG_N < LOG_N_MIN || LOG_N > LOG_N_MAX || log2_ceil(NUM_IN) != LOG_N) begin : g_bad_log_n
    $error("add_n_pipe: LOG_N must be in 1..4");
  end

  // node[k][i]: partial sum i of level k, sign-extended to the final sum width.
  logic signed [SW-1:0] node [LOG_N+1][NUM_IN];
  logic [LOG_N:1]       lvl_vld_d, lvl_vld_q;
  logic [LOG_N:0]       vld_chain;

  assign vld_chain = {lvl_vld_q, stb_in};

  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    assign node[0][i] = SW'(signed'(in[i*WIDTH +: WIDTH]));
  end

  // Each level's valid is the previous level's valid, one cycle later.
  always_comb begin
    lvl_vld_d = vld_chain[LOG_N-1:0];
  end

  // Valid pipeline registers; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) lvl_vld_q <= '0;
    else     lvl_vld_q <= lvl_vld_d;
  end

  for (genvar k = 1; k <= LOG_N; k++) begin : g_lvl
    localparam int CNT = NUM_IN >> k;
    localparam int LW  = WIDTH + k;

    logic signed [LW-1:0] sum_d [CNT];
    logic signed [LW-1:0] sum_q [CNT];

    // Pairwise sums: operands are one bit wider than their level, so no overflow; hold when idle.
    always_comb begin
      for (int i = 0; i < CNT; i++) begin
        sum_d[i] = sum_q[i];
        if (vld_chain[k-1]) sum_d[i] = LW'(node[k-1][2*i]) + LW'(node[k-1][2*i+1]);
      end
    end

    // Partial-sum registers for this level.
    always_ff @(posedge clk) begin
      for (int i = 0; i < CNT; i++) begin
        if (rst) sum_q[i] <= '0;
        else     sum_q[i] <= sum_d[i];
      end
    end

    for (genvar i = 0; i < NUM_IN; i++) begin : g_node
      if (i < CNT) begin : g_used
        assign node[k][i] = SW'(sum_q[i]);
      end else begin : g_pad
        assign node[k][i] = '0;
      end
    end
  end

  add_n_round #(
    .WIDTH      (WIDTH),
    .LOG_N      (LOG_N),
    .ROUND_MODE (ROUND_MODE)
  ) u_round (
    .clk     (clk),
    .rst     (rst),
    .sum_vld (vld_chain[LOG_N]),
    .sum_dat (node[LOG_N][0]),
    .res_vld (stb_out),
    .res_dat (out)
  );

endmodule

// File: tb/tb_add_n_pipe.sv
// Scoreboard bench: four averagers (LOG_N=2 modes 0/1/2, LOG_N=1 mode 2) checked in parallel.
// Latency: expected cycle of each result is recorded at issue and compared at stb_out.
// Backpressure: none; a monitor pops one expected entry per observed stb_out.
module tb_add_n_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in4;
  logic        stb4;
  logic [31:0] in2;
  logic        stb2;
  logic [15:0] out_w [4];
  logic        stb_w [4];

  always #5 clk = ~clk;

  add_n_pipe #(.WIDTH(16), .LOG_N(2), .ROUND_MODE(0)) u_m0 (
    .clk(clk), .rst(rst), .in(in4), .stb_in(stb4), .out(out_w[0]), .stb_out(stb_w[0]));
  add_n_pipe #(.WIDTH(16), .LOG_N(2), .ROUND_MODE(1)) u_m1 (
    .clk(clk), .rst(rst), .in(in4), .stb_in(stb4), .out(out_w[1]), .stb_out(stb_w[1]));
  add_n_pipe #(.WIDTH(16), .LOG_N(2), .ROUND_MODE(2)) u_m2 (
    .clk(clk), .rst(rst), .in(in4), .stb_in(stb4), .out(out_w[2]), .stb_out(stb_w[2]));
  add_n_pipe #(.WIDTH(16), .LOG_N(1), .ROUND_MODE(2)) u_n2 (
    .clk(clk), .rst(rst), .in(in2), .stb_in(stb2), .out(out_w[3]), .stb_out(stb_w[3]));

  typedef struct packed {
    int val;
    int cyc;
  } exp_t;

  exp_t exp_q [4][$];
  int   last_exp [4];
  int   cyc = 0;
  logic rst_seen = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0d, expected %0d (cycle %0d)", name, idx, act, exp, cyc);
    end
  endtask

  // Reference: exact real-valued average, then the rounding rule applied to it.
  function automatic int ref_avg(input int sum, input int log_n, input int mode);
    real a, fl, frac;
    int  fi;
    a    = real'(sum) / real'(1 << log_n);
    fl   = $floor(a);
    frac = a - fl;
    fi   = $rtoi(fl);
    if (mode == 1)      return (frac >= 0.5) ? fi + 1 : fi;
    else if (mode == 2) begin
      if (frac > 0.5) return fi + 1;
      if (frac < 0.5) return fi;
      return (fi % 2 == 0) ? fi : fi + 1;
    end
    return fi;
  endfunction

  task automatic push_exp(input int idx, input int val, input int lat);
    exp_t e;
    e.val = val;
    e.cyc = cyc + lat;
    exp_q[idx].push_back(e);
  endtask

  task automatic put4(input int a, input int b, input int c, input int d,
                      input bit push, input int e0, input int e1, input int e2);
    @(posedge clk); #1;
    in4  = {16'(d), 16'(c), 16'(b), 16'(a)};
    stb4 = 1'b1;
    stb2 = 1'b0;
    if (push) begin
      push_exp(0, e0, 3);
      push_exp(1, e1, 3);
      push_exp(2, e2, 3);
    end
  endtask

  task automatic put4m(input int a, input int b, input int c, input int d);
    int s;
    s = a + b + c + d;
    put4(a, b, c, d, 1'b1, ref_avg(s, 2, 0), ref_avg(s, 2, 1), ref_avg(s, 2, 2));
  endtask

  task automatic put2(input int a, input int b, input int e);
    @(posedge clk); #1;
    in2  = {16'(b), 16'(a)};
    stb2 = 1'b1;
    stb4 = 1'b0;
    push_exp(3, e, 2);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      stb4 = 1'b0;
      stb2 = 1'b0;
      in4  = 64'hDEAD_BEEF_0BAD_F00D;
      in2  = 32'hA5A5_5A5A;
    end
  endtask

  // Monitor: reset state, in-order results at the predicted cycle, and hold between strobes.
  always @(negedge clk) begin : mon
    int   o;
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      o = int'($signed(out_w[d]));
      if (rst_seen) begin
        check("rst_stb", d, int'(stb_w[d]), 0);
        check("rst_out", d, o, 0);
        last_exp[d] = 0;
      end else if (stb_w[d]) begin
        if (exp_q[d].size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_stb dut%0d: got stb_out=1 out=%0d, expected no strobe (cycle %0d)", d, o, cyc);
        end else begin
          e = exp_q[d].pop_front();
          check("out_cycle", d, cyc, e.cyc);
          check("out_val", d, o, e.val);
          last_exp[d] = e.val;
        end
      end else begin
        check("hold", d, o, last_exp[d]);
      end
    end
  end

  localparam bit [4:0] GAP_PAT = 5'b01101; // issued LSB first: 1,0,1,1,0

  initial begin
    int waited;
    rst  = 1'b1;
    stb4 = 1'b0;
    stb2 = 1'b0;
    in4  = '0;
    in2  = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single pulse: 10/4 = 2.5
    put4(1, 2, 3, 4, 1'b1, 2, 3, 2);
    idle(5);
    // Ties and small negatives: -0.25, 1.5, -0.5
    put4(-1, 0, 0, 0, 1'b1, -1, 0, 0);
    put4( 6, 0, 0, 0, 1'b1,  1, 2, 2);
    put4(-2, 0, 0, 0, 1'b1, -1, 0, 0);
    // Full-scale extremes: no wrap
    put4( 32767,  32767,  32767,  32767, 1'b1,  32767,  32767,  32767);
    put4(-32768, -32768, -32768, -32768, 1'b1, -32768, -32768, -32768);
    idle(5);

    // LOG_N=1, half-even: sums 3, 1, -1, -3
    put2( 1,  2,  2);
    put2( 0,  1,  0);
    put2(-1,  0,  0);
    put2(-2, -1, -2);
    put2( 32767,  32767,  32767);
    put2(-32768, -32768, -32768);
    idle(5);

    // Throughput: 8 back-to-back ramp samples, then a gapped pattern
    for (int c = 0; c < 8; c++) begin
      put4m(c * 4099 - 16000, 7 - c * 3001, c * c * 97 - 1, 12345 - c * 5003);
    end
    for (int g = 0; g < 5; g++) begin
      if (GAP_PAT[g]) put4m(1000 * g - 2001, -3 * g, 17 + g, -32768 + g);
      else            idle(1);
    end
    idle(6);

    // Reset with two samples in flight: they must never appear
    put4(100, 200, 300, 400, 1'b0, 0, 0, 0);
    put4(  5,   6,   7,   8, 1'b0, 0, 0, 0);
    @(posedge clk); #1;
    rst  = 1'b1;
    stb4 = 1'b0;
    @(posedge clk); #1;
    rst  = 1'b0;
    // 33/4 = 8.25
    put4(8, 8, 8, 9, 1'b1, 8, 8, 8);
    idle(6);

    waited = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    for (int d = 0; d < 4; d++) begin
      if (exp_q[d].size() != 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL missing_stb dut%0d: got no strobe, expected %0d more result(s)", d, exp_q[d].size());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
